tmr_cfg_reg_scrub: RTL and testbench

- Triplicated (TMR) configuration register that drives the three inputs of the downstream bitwise majority voter. It is the write/storage side of the voter interface.
- Holds three copies of a WIDTH-bit PLL configuration word and exposes the copies plus an internal majority value.
- Periodically scrubs: it compares the copies and rewrites the voted value into all three, which repairs single-copy upsets (SEUs).
- Counts corrections for slow-control readback and provides a test-only upset-injection port.

---
 rtl/tmr_cfg_reg_scrub.sv | 119 +++++++++++
 tb/tb_tmr_cfg_reg_scrub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_cfg_reg_scrub.sv
// Triplicated configuration register feeding a bitwise majority voter.
// A periodic scrub rewrites the voted value into all copies and counts repairs.
module tmr_cfg_reg_scrub #(
  parameter int unsigned       WIDTH        = 6,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
  parameter int unsigned       SCRUB_PERIOD = 16,
  parameter int unsigned       ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                inj_en,
  input  logic [1:0]          inj_sel,
  input  logic [WIDTH-1:0]    inj_mask,
  input  logic                err_clr,
  output logic [WIDTH-1:0]    copy_a,
  output logic [WIDTH-1:0]    copy_b,
  output logic [WIDTH-1:0]    copy_c,
  output logic [WIDTH-1:0]    q,
  output logic                mismatch,
  output logic                corrected,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned      CNT_W  = 16;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCRUB_PERIOD - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_CHECK,
    S_FIX
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_c;
  logic                r_corr;
  logic [ERRCNT_W-1:0] r_err;

  logic [WIDTH-1:0]    w_q;
  logic                w_mismatch;

  always_comb begin
    w_q        = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
    w_mismatch = (r_a != r_b) || (r_b != r_c);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_WAIT;
      r_cnt   <= RELOAD;
      r_a     <= RESET_VALUE;
      r_b     <= RESET_VALUE;
      r_c     <= RESET_VALUE;
      r_corr  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_corr <= 1'b0;
      if (wr_en) begin
        // A write abandons any pending check/fix and restarts the interval.
        r_a     <= wr_data;
        r_b     <= wr_data;
        r_c     <= wr_data;
        r_state <= S_WAIT;
        r_cnt   <= RELOAD;
      end else begin
        unique case (r_state)
          S_WAIT: begin
            if (r_cnt == '0) r_state <= S_CHECK;
            else             r_cnt   <= r_cnt - CNT_W'(1);
          end
          S_CHECK: begin
            if (w_mismatch) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= RELOAD;
            end
          end
          S_FIX: begin
            r_a     <= w_q;
            r_b     <= w_q;
            r_c     <= w_q;
            r_corr  <= 1'b1;
            if (r_err != '1) r_err <= r_err + ERRCNT_W'(1);
            r_state <= S_WAIT;
            r_cnt   <= RELOAD;
          end
          default: begin
            r_state <= S_WAIT;
            r_cnt   <= RELOAD;
          end
        endcase
        if (inj_en && r_state != S_FIX) begin
          case (inj_sel)
            2'd0:    r_a <= r_a ^ inj_mask;
            2'd1:    r_b <= r_b ^ inj_mask;
            2'd2:    r_c <= r_c ^ inj_mask;
            default: ;
          endcase
        end
      end
      // Placed last so a clear overrides a coincident scrub increment.
      if (err_clr) r_err <= '0;
    end
  end

  assign copy_a    = r_a;
  assign copy_b    = r_b;
  assign copy_c    = r_c;
  assign q         = w_q;
  assign mismatch  = w_mismatch;
  assign corrected = r_corr;
  assign err_cnt   = r_err;

endmodule

// File: tb/tb_tmr_cfg_reg_scrub.sv
// Randomised and directed bench for tmr_cfg_reg_scrub with a queue scoreboard
// fed by a cycle-level reference model of the scrub/write/inject rules.
module tb_tmr_cfg_reg_scrub;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_data = '0;
  logic       inj_en = 1'b0;
  logic [1:0] inj_sel = 2'd3;
  logic [5:0] inj_mask = '0;
  logic       err_clr = 1'b0;

  logic [5:0] copy_a, copy_b, copy_c, q;
  logic       mismatch, corrected;
  logic [7:0] err_cnt;

  logic [5:0] copy_a2, copy_b2, copy_c2, q2;
  logic       mismatch2, corrected2;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  tmr_cfg_reg_scrub #(
    .WIDTH(6), .RESET_VALUE(6'b000000), .SCRUB_PERIOD(P), .ERRCNT_W(8)
  ) u_dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr),
    .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c), .q(q),
    .mismatch(mismatch), .corrected(corrected), .err_cnt(err_cnt)
  );

  tmr_cfg_reg_scrub #(
    .WIDTH(6), .RESET_VALUE(6'b000000), .SCRUB_PERIOD(P), .ERRCNT_W(2)
  ) u_dut2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .err_clr(err_clr),
    .copy_a(copy_a2), .copy_b(copy_b2), .copy_c(copy_c2), .q(q2),
    .mismatch(mismatch2), .corrected(corrected2), .err_cnt(err_cnt2)
  );

  typedef struct {
    logic [5:0] a, b, c, q;
    logic       mm, corr;
    logic [7:0] err8;
    logic [1:0] err2;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: m_age counts cycles since the scrub interval was armed.
  // Age P is the compare cycle; age P+1 exists only when a repair is due.
  logic [5:0] m_a, m_b, m_c;
  int         m_err  = 0;
  bit         m_corr = 1'b0;
  int         m_age  = 0;

  function automatic logic [5:0] vote(input logic [5:0] a, b, c);
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rs, input bit wr, input logic [5:0] wd, input bit ie,
                      input logic [1:0] is, input logic [5:0] im, input bit ec);
    exp_t       e;
    logic [5:0] v;
    bit         differ;
    @(negedge clk);
    rstn = rs; wr_en = wr; wr_data = wd; inj_en = ie; inj_sel = is;
    inj_mask = im; err_clr = ec;
    if (!rs) begin
      m_a = '0; m_b = '0; m_c = '0; m_err = 0; m_corr = 1'b0; m_age = 0;
    end else if (wr) begin
      m_a = wd; m_b = wd; m_c = wd; m_corr = 1'b0; m_age = 0;
      if (ec) m_err = 0;
    end else if (m_age == P + 1) begin
      v = vote(m_a, m_b, m_c);
      m_a = v; m_b = v; m_c = v;
      m_err++; m_corr = 1'b1; m_age = 0;
      if (ec) m_err = 0;
    end else begin
      differ = (m_a != m_b) || (m_b != m_c);
      if (ie) begin
        if (is == 2'd0) m_a = m_a ^ im;
        if (is == 2'd1) m_b = m_b ^ im;
        if (is == 2'd2) m_c = m_c ^ im;
      end
      m_corr = 1'b0;
      if (m_age == P) m_age = differ ? P + 1 : 0;
      else            m_age++;
      if (ec) m_err = 0;
    end
    e.a = m_a; e.b = m_b; e.c = m_c; e.q = vote(m_a, m_b, m_c);
    e.mm = (m_a != m_b) || (m_b != m_c);
    e.corr = m_corr;
    e.err8 = (m_err > 255) ? 8'hFF : 8'(m_err);
    e.err2 = (m_err > 3) ? 2'd3 : 2'(m_err);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 6'($urandom), 0, 2'd3, 6'($urandom), 0);
  endtask

  task automatic wait_age(input int target);
    int k;
    k = 0;
    while (m_age != target && k < 200) begin
      idle(1);
      k++;
    end
    if (m_age != target) begin
      n_assert++; n_fail++;
      $display("FAIL wait_age timeout: age %0d expected %0d", m_age, target);
    end
  endtask

  task automatic inject(input logic [1:0] sel, input logic [5:0] mask);
    step(1, 0, 6'($urandom), 1, sel, mask, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("copy_a", {2'b00, copy_a}, {2'b00, e.a});
        chk("copy_b", {2'b00, copy_b}, {2'b00, e.b});
        chk("copy_c", {2'b00, copy_c}, {2'b00, e.c});
        chk("q", {2'b00, q}, {2'b00, e.q});
        chk("mismatch", {7'd0, mismatch}, {7'd0, e.mm});
        chk("corrected", {7'd0, corrected}, {7'd0, e.corr});
        chk("err_cnt", err_cnt, e.err8);
        chk("err_cnt_w2", {6'd0, err_cnt2}, {6'd0, e.err2});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [5:0] msk;
    step(0, 0, '0, 0, 2'd3, '0, 0);
    step(0, 0, '0, 0, 2'd3, '0, 0);
    idle(40);

    // write, then upset copy B and let the scrub repair it
    step(1, 1, 6'h2A, 0, 2'd3, '0, 0);
    idle(3);
    inject(2'd1, 6'h05);
    wait_age(P + 1);
    idle(3);

    // upsets before and during the compare cycle, write lands on the repair cycle
    wait_age(P - 1);
    inject(2'd2, 6'h10);
    inject(2'd0, 6'h01);
    step(1, 1, 6'h11, 0, 2'd3, '0, 0);
    idle(5);

    // same bit flipped in two copies: the wrong value wins the vote
    step(1, 1, 6'h00, 0, 2'd3, '0, 0);
    inject(2'd0, 6'h01);
    inject(2'd1, 6'h01);
    wait_age(P + 1);
    idle(3);

    // different bits in different copies are repaired together
    inject(2'd0, 6'h01);
    inject(2'd2, 6'h20);
    wait_age(P + 1);
    idle(2);

    for (int i = 0; i < 5; i++) begin
      msk = 6'($urandom_range(1, 63));
      inject(2'($urandom_range(0, 2)), msk);
      wait_age(P + 1);
      idle(1);
    end

    // clear coinciding with a repair increment
    inject(2'd1, 6'h08);
    wait_age(P + 1);
    step(1, 0, '0, 1, 2'd0, 6'h3F, 1);
    idle(2);

    // reset asserted on the repair cycle
    inject(2'd2, 6'h04);
    wait_age(P + 1);
    step(0, 0, '0, 0, 2'd3, '0, 0);
    idle(3);

    for (int i = 0; i < 900; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 19) == 0), 6'($urandom),
           ($urandom_range(0, 5) == 0), 2'($urandom), 6'($urandom),
           ($urandom_range(0, 29) == 0));
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
